// File: rtl/laplace_pkg.sv
// Shared definitions for the Laplace datapath (window buffer, adder tree, clamp).
// Provides the default pixel width, tap index constants and a counter-width helper.
package laplace_pkg;

  localparam int unsigned LAPLACE_PIX_W = 8;
  localparam int unsigned NUM_TAPS      = 5;

  // Position of each operand in a packed tap vector
  typedef enum logic [2:0] {
    TAP_C = 3'd0,
    TAP_N = 3'd1,
    TAP_S = 3'd2,
    TAP_E = 3'd3,
    TAP_W = 3'd4
  } tap_e;

  // Bits needed to count 0..n-1, never less than one
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/laplace_line_ram.sv
// One image row of pixel storage.
// Ports: clk; we/addr/wdata synchronous write; rdata asynchronous read of addr.
// Contents are not reset; the window buffer never consumes a row it has not written.
module laplace_line_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Read sees the old word while a write to the same address is pending
  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

endmodule

// File: rtl/laplace_window_buffer.sv
// Streaming line buffer feeding the Laplace adder tree.
// Takes a raster-order grayscale frame and, per interior pixel, emits the
// centre and its four neighbours as raw copies. One pixel per clock.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready/in_pix   pixel input handshake
//   out_valid/out_ready        operand-set output handshake
//   out_c/n/s/w/e              centre (r-1,c-1) and its neighbours
//   out_last                   flags the final set of a frame
module laplace_window_buffer
  import laplace_pkg::*;
#(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned PIX_W = LAPLACE_PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_c,
  output logic [PIX_W-1:0] out_n,
  output logic [PIX_W-1:0] out_s,
  output logic [PIX_W-1:0] out_w,
  output logic [PIX_W-1:0] out_e,
  output logic             out_last
);

  localparam int unsigned COL_W = clog2_min1(IMG_W);
  localparam int unsigned ROW_W = clog2_min1(IMG_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  // Window rows: [0]=top (r-2), [1]=mid (r-1), [2]=bottom (r); cols [0]=c-2 .. [2]=c
  logic [2:0][2:0][PIX_W-1:0]       win_q, win_d;
  logic [NUM_TAPS-1:0][PIX_W-1:0]   taps_q, taps_d;
  logic                             out_valid_q, out_valid_d;
  logic                             out_last_q, out_last_d;

  logic             accept;
  logic [PIX_W-1:0] lb1_rdata;
  logic [PIX_W-1:0] lb2_rdata;

  // Single output register: free when empty or being drained this edge
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // lb1 holds row r-1, lb2 holds row r-2; lb2 is refilled from lb1's old word
  laplace_line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (in_pix),
    .rdata (lb1_rdata)
  );

  laplace_line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (lb1_rdata),
    .rdata (lb2_rdata)
  );

  // Window shift, raster counters and output-register update
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    taps_d      = taps_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    // Pending set is taken; a new set accepted on this edge overrides below
    if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (accept) begin
      win_d[0] = {lb2_rdata, win_q[0][2:1]};
      win_d[1] = {lb1_rdata, win_q[1][2:1]};
      win_d[2] = {in_pix,    win_q[2][2:1]};

      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      // Row/col gating also hides stale window columns carried across rows/frames
      if (row_q >= ROW_W'(2) && col_q >= COL_W'(2)) begin
        out_valid_d   = 1'b1;
        out_last_d    = (row_q == ROW_MAX) && (col_q == COL_MAX);
        taps_d[TAP_C] = win_d[1][1];
        taps_d[TAP_N] = win_d[0][1];
        taps_d[TAP_S] = win_d[2][1];
        taps_d[TAP_W] = win_d[1][0];
        taps_d[TAP_E] = win_d[1][2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      taps_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      taps_q      <= taps_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_c     = taps_q[TAP_C];
  assign out_n     = taps_q[TAP_N];
  assign out_s     = taps_q[TAP_S];
  assign out_w     = taps_q[TAP_W];
  assign out_e     = taps_q[TAP_E];

endmodule

// File: tb/tb_laplace_window_buffer.sv
// Scoreboard bench for laplace_window_buffer: a 4x4 instance for directed
// frames and a 64x64 instance for a random frame with random backpressure.
module tb_laplace_window_buffer;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] n;
    logic [7:0] s;
    logic [7:0] w;
    logic [7:0] e;
    logic       last;
  } set_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       in_valid;
  logic [7:0] in_pix;
  logic       out_ready;

  logic       s_in_valid, s_in_ready, s_out_valid, s_out_last;
  logic [7:0] s_c, s_n, s_s, s_w, s_e;
  logic       l_in_valid, l_in_ready, l_out_valid, l_out_last;
  logic [7:0] l_c, l_n, l_s, l_w, l_e;

  logic       d_in_ready, d_out_valid;
  set_t       d_set;

  always #5 clk = ~clk;

  assign s_in_valid  = in_valid && !sel;
  assign l_in_valid  = in_valid && sel;
  assign d_in_ready  = sel ? l_in_ready : s_in_ready;
  assign d_out_valid = sel ? l_out_valid : s_out_valid;
  assign d_set = sel ? {l_c, l_n, l_s, l_w, l_e, l_out_last}
                     : {s_c, s_n, s_s, s_w, s_e, s_out_last};

  laplace_window_buffer #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_pix(in_pix), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_c(s_c), .out_n(s_n), .out_s(s_s), .out_w(s_w), .out_e(s_e),
    .out_last(s_out_last)
  );

  laplace_window_buffer #(.IMG_W(64), .IMG_H(64), .PIX_W(8)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_pix(in_pix), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_c(l_c), .out_n(l_n), .out_s(l_s), .out_w(l_w), .out_e(l_e),
    .out_last(l_out_last)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   cur_w, cur_h, m_row, m_col;
  int   n_sets, n_last;
  bit   rand_mode, lat_check;
  logic [7:0] img [64][64];
  set_t sb[$];
  int   pc[$];
  set_t obs[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Golden neighbourhood model: store the frame as it streams in
  function automatic void model_accept(input logic [7:0] pix);
    set_t e;
    img[m_row][m_col] = pix;
    if (m_row >= 2 && m_col >= 2) begin
      e.c    = img[m_row-1][m_col-1];
      e.n    = img[m_row-2][m_col-1];
      e.s    = img[m_row][m_col-1];
      e.w    = img[m_row-1][m_col-2];
      e.e    = img[m_row-1][m_col];
      e.last = (m_row == cur_h-1) && (m_col == cur_w-1);
      sb.push_back(e);
      pc.push_back(cyc);
    end
    if (m_col == cur_w-1) begin
      m_col = 0;
      m_row = (m_row == cur_h-1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endfunction

  function automatic void model_reset();
    m_row = 0;
    m_col = 0;
    sb.delete();
    pc.delete();
  endfunction

  function automatic void stats_reset();
    n_sets = 0;
    n_last = 0;
    obs.delete();
  endfunction

  function automatic bit pick_rdy();
    return rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  // One clock: drive after the edge, sample at negedge, transfers happen at next posedge
  task automatic cycle(input bit v, input logic [7:0] pix, input bit rdy, output bit acc);
    set_t e;
    int   pcy;
    in_valid  = v;
    in_pix    = pix;
    out_ready = rdy;
    @(negedge clk);
    acc = v && d_in_ready;
    if (d_out_valid && rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_set", 64'(1), 64'(0));
      end else begin
        e   = sb.pop_front();
        pcy = pc.pop_front();
        check("set", 64'(d_set), 64'(e));
        if (lat_check) check("latency", 64'(cyc - pcy), 64'(1));
      end
      obs.push_back(d_set);
      n_sets++;
      if (d_set.last) n_last++;
    end
    if (acc) model_accept(pix);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [7:0] pix);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    if (rand_mode && $urandom_range(0, 3) == 0) cycle(1'b0, 8'h00, pick_rdy(), acc);
    acc = 1'b0;
    while (!acc && tries < 100) begin
      cycle(1'b1, pix, pick_rdy(), acc);
      tries++;
    end
    if (!acc) check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    bit acc;
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      cycle(1'b0, 8'h00, 1'b1, acc);
      k++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
    check("drain_idle", 64'(d_out_valid), 64'(0));
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < 16; i++) send(8'(base + i));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_pix = 8'h00; out_ready = 1'b1;
    rand_mode = 1'b0; lat_check = 1'b1; cur_w = 4; cur_h = 4;
    model_reset();
    stats_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(d_out_valid), 64'(0));
    check("rst_set", 64'(d_set), 64'(0));
    check("rst_in_ready", 64'(d_in_ready), 64'(1));
    check("rst_l_valid", 64'(l_out_valid), 64'(0));
    rst_n = 1'b1;

    // Single 4x4 frame, no backpressure
    send_frame(0);
    drain();
    check("f1_sets", 64'(n_sets), 64'(4));
    check("f1_first", 64'(obs[0]), 64'({8'd5, 8'd1, 8'd9, 8'd4, 8'd6, 1'b0}));
    check("f1_final", 64'(obs[3]), 64'({8'd10, 8'd6, 8'd14, 8'd9, 8'd11, 1'b1}));
    check("f1_order", 64'({obs[0].c, obs[1].c, obs[2].c, obs[3].c}),
          64'({8'd5, 8'd6, 8'd9, 8'd10}));

    // Stall the first set for 5 clocks
    stats_reset();
    lat_check = 1'b0;
    for (int i = 0; i <= 10; i++) send(8'(i));
    check("stall_pending", 64'(d_out_valid), 64'(1));
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 8'd11, 1'b0, acc);
      check("stall_acc", 64'(acc), 64'(0));
      check("stall_in_ready", 64'(d_in_ready), 64'(0));
      check("stall_valid", 64'(d_out_valid), 64'(1));
      check("stall_c", 64'(d_set.c), 64'(5));
    end
    for (int i = 11; i < 16; i++) send(8'(i));
    drain();
    lat_check = 1'b1;
    check("stall_sets", 64'(n_sets), 64'(4));
    check("stall_order", 64'({obs[0].c, obs[1].c, obs[2].c, obs[3].c}),
          64'({8'd5, 8'd6, 8'd9, 8'd10}));

    // Back-to-back frames
    stats_reset();
    send_frame(0);
    send_frame(100);
    drain();
    check("b2b_sets", 64'(n_sets), 64'(8));
    check("b2b_lasts", 64'(n_last), 64'(2));
    check("b2b_f2_first", 64'(obs[4]), 64'({8'd105, 8'd101, 8'd109, 8'd104, 8'd106, 1'b0}));

    // Reset mid-frame after pixel 7
    stats_reset();
    for (int i = 0; i < 8; i++) send(8'(i));
    rst_n = 1'b0;
    cycle(1'b0, 8'h00, 1'b1, acc);
    check("midrst_valid", 64'(d_out_valid), 64'(0));
    check("midrst_pending", 64'(sb.size()), 64'(0));
    rst_n = 1'b1;
    model_reset();
    send_frame(0);
    drain();
    check("midrst_sets", 64'(n_sets), 64'(4));
    check("midrst_first", 64'(obs[0]), 64'({8'd5, 8'd1, 8'd9, 8'd4, 8'd6, 1'b0}));

    // 64x64 random frame, random valid and ready
    sel = 1'b1; cur_w = 64; cur_h = 64; rand_mode = 1'b1; lat_check = 1'b0;
    rst_n = 1'b0;
    cycle(1'b0, 8'h00, 1'b1, acc);
    rst_n = 1'b1;
    model_reset();
    stats_reset();
    for (int i = 0; i < 64*64; i++) send(8'($urandom_range(0, 255)));
    drain();
    check("big_sets", 64'(n_sets), 64'(3844));
    check("big_lasts", 64'(n_last), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
